// File: rtl/uart_top_rx.sv
// UART receiver: 16x oversampling baud-tick generator, 2-FF line synchroniser and
// start/data/stop deserialiser producing a word, a one-cycle done strobe and a framing flag.
module uart_top_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [10:0]          dvsr,
    input  logic                 rx_in,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [10:0]           baud_cnt_q;
    logic                  tick;
    logic                  rx_meta_q, rx_s, rx_prev_q;
    logic                  fall;
    logic [3:0]            s_cnt_q, s_cnt_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  d_out_q, d_out_d;
    logic                  fe_q, fe_d;
    logic                  done_q, done_d;

    // Free-running baud counter; the receiver re-aligns only to whole ticks.
    assign tick = (baud_cnt_q == dvsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) baud_cnt_q <= '0;
        else        baud_cnt_q <= tick ? 11'd0 : baud_cnt_q + 11'd1;
    end

    // Synchroniser and edge register reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s      <= rx_meta_q;
            rx_prev_q <= rx_s;
        end
    end

    // Only a genuine high-to-low transition starts a frame; a held-low line does not.
    assign fall = rx_prev_q & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            shift_q <= '0;
            d_out_q <= '0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            d_out_q <= d_out_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shift_d = shift_q;
        d_out_d = d_out_q;
        fe_d    = fe_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == 4'd15) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_q == NW'(DATA_BITS - 1)) state_d = STOP;
                        else                           n_d = n_q + 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught at once.
                if (tick) begin
                    if (s_cnt_q == 4'(SB_TICK - 1)) begin
                        d_out_d = shift_q;
                        fe_d    = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_done   = done_q;
    assign d_out     = d_out_q;
    assign frame_err = fe_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_top_rx.sv
// Directed bench for uart_top_rx: drives serial frames at dvsr=2 (48 clk per bit)
// and checks received words, strobes, framing flag and reset behaviour.
module tb_uart_top_rx;

    localparam int BIT_CLK = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dvsr = 11'd2;
    logic        rx_in = 1'b1;
    logic        rx_done;
    logic [7:0]  d_out;
    logic        frame_err;
    logic        rx_busy;

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    logic [7:0] dq[$];
    logic       fq[$];
    int         tq[$];

    uart_top_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
        .clk(clk), .rst_n(rst_n), .dvsr(dvsr), .rx_in(rx_in),
        .rx_done(rx_done), .d_out(d_out), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Every cycle with rx_done high is logged, so a stretched strobe shows as extra entries.
    always @(negedge clk) begin
        cyc++;
        if (rx_done === 1'b1) begin
            dq.push_back(d_out);
            fq.push_back(frame_err);
            tq.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of the frame start/d0..d7/stop.
    task automatic send_bits(input logic [7:0] data, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = fr[i];
            idle(BIT_CLK);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        idle(3);
        checks++; if (d_out !== 8'h00)   begin failures++; $display("FAIL reset_d_out got=%h exp=00", d_out); end
        checks++; if (rx_done !== 1'b0)  begin failures++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (rx_busy !== 1'b0)  begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
        rst_n = 1'b1;
        idle(200);
        checks++; if (dq.size() != 0) begin failures++; $display("FAIL idle_no_done got=%0d exp=0", dq.size()); end
    endtask

    task automatic test_single();
        int n0;
        n0 = dq.size();
        send_bits(8'hAA, 1'b1, 10);
        idle(100);
        checks++; if (dq.size() - n0 != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", dq.size() - n0); end
        if (dq.size() > n0) begin
            checks++; if (dq[n0] !== 8'hAA) begin failures++; $display("FAIL single_strobe_data got=%h exp=aa", dq[n0]); end
        end
        checks++; if (d_out !== 8'hAA)   begin failures++; $display("FAIL single_d_out got=%h exp=aa", d_out); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL single_frame_err got=%b exp=0", frame_err); end
        checks++; if (rx_busy !== 1'b0)  begin failures++; $display("FAIL single_busy got=%b exp=0", rx_busy); end
    endtask

    task automatic test_back_to_back();
        int n0, gap;
        n0 = dq.size();
        send_bits(8'h55, 1'b1, 10);
        send_bits(8'hC3, 1'b1, 10);
        idle(100);
        checks++; if (dq.size() - n0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", dq.size() - n0); end
        if (dq.size() - n0 == 2) begin
            checks++; if (dq[n0] !== 8'h55)   begin failures++; $display("FAIL b2b_first got=%h exp=55", dq[n0]); end
            checks++; if (dq[n0+1] !== 8'hC3) begin failures++; $display("FAIL b2b_second got=%h exp=c3", dq[n0+1]); end
            checks++; if (fq[n0] !== 1'b0 || fq[n0+1] !== 1'b0) begin
                failures++; $display("FAIL b2b_frame_err got=%b%b exp=00", fq[n0], fq[n0+1]);
            end
            gap = tq[n0+1] - tq[n0];
            checks++; if (gap < 477 || gap > 483) begin failures++; $display("FAIL b2b_gap got=%0d exp=480+-3", gap); end
        end
    endtask

    task automatic test_false_start();
        int  n0;
        bit  seen;
        n0 = dq.size();
        seen = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_busy === 1'b1) seen = 1;
        end
        rx_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_busy === 1'b1) seen = 1;
        end
        idle(200);
        checks++; if (!seen) begin failures++; $display("FAIL false_busy_rise got=0 exp=1"); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL false_busy_fall got=%b exp=0", rx_busy); end
        checks++; if (dq.size() != n0) begin failures++; $display("FAIL false_no_done got=%0d exp=0", dq.size() - n0); end
        checks++; if (d_out !== 8'hC3) begin failures++; $display("FAIL false_d_out got=%h exp=c3", d_out); end
    endtask

    task automatic test_frame_err();
        int n0;
        n0 = dq.size();
        send_bits(8'h0F, 1'b0, 10);
        idle(1000);
        checks++; if (dq.size() - n0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", dq.size() - n0); end
        checks++; if (d_out !== 8'h0F)   begin failures++; $display("FAIL ferr_d_out got=%h exp=0f", d_out); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
        checks++; if (rx_busy !== 1'b0)  begin failures++; $display("FAIL ferr_break_busy got=%b exp=0", rx_busy); end
        rx_in = 1'b1;
        idle(100);
        checks++; if (dq.size() - n0 != 1) begin failures++; $display("FAIL ferr_break_frames got=%0d exp=1", dq.size() - n0); end
        send_bits(8'h81, 1'b1, 10);
        idle(100);
        checks++; if (d_out !== 8'h81)   begin failures++; $display("FAIL ferr_recover_d_out got=%h exp=81", d_out); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_recover_flag got=%b exp=0", frame_err); end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        send_bits(8'hA5, 1'b1, 5);
        rx_in = 1'b0;
        idle(20);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", rx_busy); end
        n0 = dq.size();
        #2;
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        checks++; if (d_out !== 8'h00) begin failures++; $display("FAIL mid_async_d_out got=%h exp=00", d_out); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", rx_busy); end
        idle(5);
        rst_n = 1'b1;
        idle(600);
        checks++; if (dq.size() != n0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dq.size() - n0); end
        send_bits(8'h3C, 1'b1, 10);
        idle(100);
        checks++; if (dq.size() - n0 != 1) begin failures++; $display("FAIL mid_next_pulses got=%0d exp=1", dq.size() - n0); end
        checks++; if (d_out !== 8'h3C)   begin failures++; $display("FAIL mid_next_d_out got=%h exp=3c", d_out); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_next_flag got=%b exp=0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
